// File: rtl/fb_fill.sv
// Rectangle fill engine: CPU-programmed origin/size/colour, clipped to the framebuffer,
// streamed one pixel per cycle over a valid/ready write port. Optional irq output: FB_FILL_IRQ_EN.
module fb_fill #(
    parameter int FB_W  = 320,
    parameter int FB_H  = 240,
    parameter int PIX_W = 12,
    parameter int FB_AW = 17
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             io_we,
    input  logic [1:0]       io_addr,
    input  logic [31:0]      io_wdata,
    output logic [31:0]      io_rdata,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [PIX_W-1:0] fb_wdata,
    input  logic             fb_ready
`ifdef FB_FILL_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam logic [15:0]      FB_W16 = 16'(FB_W);
    localparam logic [15:0]      FB_H16 = 16'(FB_H);
    localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(FB_W);

    typedef enum logic [1:0] {IDLE, CLIP, FILL} state_t;

    state_t             state_q, state_d;
    logic [31:0]        origin_q, origin_d, size_q, size_d;
    logic [PIX_W-1:0]   color_q, color_d;
    logic               fb_we_q, fb_we_d, err_q, err_d;
    logic [FB_AW-1:0]   fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]   fb_wdata_q, fb_wdata_d;
    logic               irq_pend;
`ifdef FB_FILL_IRQ_EN
    logic               irq_pend_q, irq_pend_d;
    assign irq_pend = irq_pend_q;
    assign irq      = irq_pend_q;
`else
    assign irq_pend = 1'b0;
`endif

    // Snapshot and scan state; only meaningful once CLIP has loaded it, so left unreset.
    logic [15:0]        sx_q, sx_d, sy_q, sy_d, sw_q, sw_d, sh_q, sh_d;
    logic [PIX_W-1:0]   scol_q, scol_d;
    logic [15:0]        cx_q, cx_d, cy_q, cy_d, xlim_q, xlim_d, ylim_q, ylim_d;
    logic [FB_AW-1:0]   row_q, row_d;

    logic               wr_ctrl, busy, reject, last_col, last_row;
    logic [16:0]        x_sum, y_sum;
    logic [FB_AW-1:0]   first_row;

    assign busy      = (state_q != IDLE);
    assign wr_ctrl   = io_we && (io_addr == 2'd3);
    assign x_sum     = {1'b0, sx_q} + {1'b0, sw_q};
    assign y_sum     = {1'b0, sy_q} + {1'b0, sh_q};
    assign reject    = (sx_q >= FB_W16) || (sy_q >= FB_H16) || (sw_q == 16'd0) || (sh_q == 16'd0);
    // One-time constant multiply at fill start; the per-pixel path only adds.
    assign first_row = FB_AW'(sy_q) * ROW_STEP;
    assign last_col  = ((cx_q + 16'd1) == xlim_q);
    assign last_row  = ((cy_q + 16'd1) == ylim_q);

    always_comb begin
        state_d    = state_q;
        origin_d   = origin_q;
        size_d     = size_q;
        color_d    = color_q;
        fb_we_d    = fb_we_q;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        err_d      = err_q;
`ifdef FB_FILL_IRQ_EN
        irq_pend_d = irq_pend_q;
`endif
        sx_d       = sx_q;
        sy_d       = sy_q;
        sw_d       = sw_q;
        sh_d       = sh_q;
        scol_d     = scol_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        xlim_d     = xlim_q;
        ylim_d     = ylim_q;
        row_d      = row_q;

        if (io_we) begin
            case (io_addr)
                2'd0:    origin_d = io_wdata;
                2'd1:    size_d   = io_wdata;
                2'd2:    color_d  = io_wdata[PIX_W-1:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (wr_ctrl && io_wdata[0]) begin
                    state_d = CLIP;
                    err_d   = 1'b0;
                    sx_d    = origin_q[15:0];
                    sy_d    = origin_q[31:16];
                    sw_d    = size_q[15:0];
                    sh_d    = size_q[31:16];
                    scol_d  = color_q;
                end
            end
            CLIP: begin
                if (reject) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
`ifdef FB_FILL_IRQ_EN
                    irq_pend_d = 1'b1;
`endif
                end else begin
                    state_d    = FILL;
                    xlim_d     = (x_sum > {1'b0, FB_W16}) ? FB_W16 : x_sum[15:0];
                    ylim_d     = (y_sum > {1'b0, FB_H16}) ? FB_H16 : y_sum[15:0];
                    cx_d       = sx_q;
                    cy_d       = sy_q;
                    row_d      = first_row;
                    fb_addr_d  = first_row + FB_AW'(sx_q);
                    fb_wdata_d = scol_q;
                    fb_we_d    = 1'b1;
                end
            end
            FILL: begin
                if (fb_we_q && fb_ready) begin
                    if (last_col && last_row) begin
                        fb_we_d = 1'b0;
                        state_d = IDLE;
`ifdef FB_FILL_IRQ_EN
                        irq_pend_d = 1'b1;
`endif
                    end else if (last_col) begin
                        cx_d      = sx_q;
                        cy_d      = cy_q + 16'd1;
                        row_d     = row_q + ROW_STEP;
                        fb_addr_d = row_q + ROW_STEP + FB_AW'(sx_q);
                    end else begin
                        cx_d      = cx_q + 16'd1;
                        fb_addr_d = fb_addr_q + FB_AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Acknowledge comes last so it beats a same-cycle completion.
        if (wr_ctrl && io_wdata[1]) begin
            err_d = 1'b0;
`ifdef FB_FILL_IRQ_EN
            irq_pend_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            origin_q   <= '0;
            size_q     <= '0;
            color_q    <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            err_q      <= 1'b0;
`ifdef FB_FILL_IRQ_EN
            irq_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            origin_q   <= origin_d;
            size_q     <= size_d;
            color_q    <= color_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
            err_q      <= err_d;
`ifdef FB_FILL_IRQ_EN
            irq_pend_q <= irq_pend_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        sx_q   <= sx_d;
        sy_q   <= sy_d;
        sw_q   <= sw_d;
        sh_q   <= sh_d;
        scol_q <= scol_d;
        cx_q   <= cx_d;
        cy_q   <= cy_d;
        xlim_q <= xlim_d;
        ylim_q <= ylim_d;
        row_q  <= row_d;
    end

    always_comb begin
        io_rdata = 32'd0;
        case (io_addr)
            2'd0:    io_rdata = origin_q;
            2'd1:    io_rdata = size_q;
            2'd2:    io_rdata = 32'(color_q);
            default: io_rdata = {29'd0, irq_pend, err_q, busy};
        endcase
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;

endmodule

// File: tb/tb_fb_fill.sv
// Directed bench for fb_fill: fill sequences, clipping, rejects, stalls, reset abort, irq.
module tb_fb_fill;

    logic        clk = 1'b0;
    logic        resetn;
    logic        io_we;
    logic [1:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [11:0] fb_wdata;
    logic        fb_ready;
`ifdef FB_FILL_IRQ_EN
    logic        irq;
    localparam logic [31:0] IRQ_V = 32'h4;
`else
    localparam logic [31:0] IRQ_V = 32'h0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_a[16];

    fb_fill dut (
        .clk      (clk),
        .resetn   (resetn),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_wdata (fb_wdata),
        .fb_ready (fb_ready)
`ifdef FB_FILL_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        io_we = 1'b1; io_addr = a; io_wdata = d;
        @(posedge clk); #1;
        io_we = 1'b0; io_addr = 2'd3; io_wdata = 32'd0;
    endtask

    // Start a fill with fb_ready held high and expect n writes on consecutive cycles.
    task automatic check_seq(input string tag, input int n, input logic [11:0] col);
        wr(2'd3, 32'd1);
        @(negedge clk);
        chk({tag, "_clip_we"}, 32'(fb_we), 32'd0);
        chk({tag, "_clip_busy"}, 32'(io_rdata[0]), 32'd1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_we"}, 32'(fb_we), 32'd1);
            chk({tag, "_addr"}, 32'(fb_addr), exp_a[i]);
            chk({tag, "_data"}, 32'(fb_wdata), 32'(col));
        end
        @(negedge clk);
        chk({tag, "_end_we"}, 32'(fb_we), 32'd0);
        chk({tag, "_end_ctrl"}, io_rdata, IRQ_V);
    endtask

    task automatic check_reject(input string tag);
        wr(2'd3, 32'd1);
        @(negedge clk);
        chk({tag, "_clip_we"}, 32'(fb_we), 32'd0);
        chk({tag, "_clip_busy"}, 32'(io_rdata[0]), 32'd1);
        @(negedge clk);
        chk({tag, "_we2"}, 32'(fb_we), 32'd0);
        @(negedge clk);
        chk({tag, "_we3"}, 32'(fb_we), 32'd0);
        chk({tag, "_ctrl3"}, io_rdata, 32'h2 | IRQ_V);
    endtask

    initial begin
        logic [31:0] pat;
        int k;
        int nwr;
        resetn = 1'b0; io_we = 1'b0; io_addr = 2'd3; io_wdata = 32'd0; fb_ready = 1'b1;
        pat = 32'b1011_0010_1110_1001_0111_0100_1101_1011;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_wdata", 32'(fb_wdata), 32'd0);
        chk("rst_ctrl", io_rdata, 32'd0);
        io_addr = 2'd0; #1; chk("rst_origin", io_rdata, 32'd0);
        io_addr = 2'd1; #1; chk("rst_size", io_rdata, 32'd0);
        io_addr = 2'd2; #1; chk("rst_color", io_rdata, 32'd0);
        io_addr = 2'd3;
        resetn = 1'b1;

        // Basic 3x2 fill at (2,1)
        wr(2'd0, {16'd1, 16'd2});
        wr(2'd1, {16'd2, 16'd3});
        wr(2'd2, 32'hF00);
        io_addr = 2'd2; #1; chk("rd_color", io_rdata, 32'hF00);
        io_addr = 2'd0; #1; chk("rd_origin", io_rdata, 32'h0001_0002);
        io_addr = 2'd3;
        exp_a[0] = 322; exp_a[1] = 323; exp_a[2] = 324;
        exp_a[3] = 642; exp_a[4] = 643; exp_a[5] = 644;
        check_seq("fill3x2", 6, 12'hF00);

        // Bottom-right corner clip
        wr(2'd0, {16'd239, 16'd318});
        wr(2'd1, {16'd10, 16'd10});
        wr(2'd2, 32'h0A5);
        exp_a[0] = 76798; exp_a[1] = 76799;
        check_seq("corner", 2, 12'h0A5);

        // Rejects: zero width, then x off-screen
        wr(2'd0, {16'd0, 16'd0});
        wr(2'd1, {16'd5, 16'd0});
        check_reject("w0");
        wr(2'd0, {16'd0, 16'd320});
        wr(2'd1, {16'd3, 16'd3});
        check_reject("x320");
        wr(2'd3, 32'h2);
        @(negedge clk);
        chk("ack_ctrl", io_rdata, 32'd0);

        // 4x4 fill at (10,5) with fb_ready stalls, a start while busy, and an ORIGIN rewrite
        wr(2'd0, {16'd5, 16'd10});
        wr(2'd1, {16'd4, 16'd4});
        wr(2'd2, 32'h3C7);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_a[r*4+c] = 1610 + 320*r + c;
        fb_ready = 1'b0;
        wr(2'd3, 32'd1);
        @(negedge clk);
        chk("stall_clip_we", 32'(fb_we), 32'd0);
        k = 0;
        for (int j = 0; j < 100 && k < 16; j++) begin
            @(posedge clk); #1;
            fb_ready = pat[j % 32];
            io_we = 1'b0; io_addr = 2'd3; io_wdata = 32'd0;
            if (j == 3) begin io_we = 1'b1; io_addr = 2'd3; io_wdata = 32'd1; end
            if (j == 6) begin io_we = 1'b1; io_addr = 2'd0; io_wdata = 32'd0; end
            @(negedge clk);
            chk("stall_we", 32'(fb_we), 32'd1);
            chk("stall_addr", 32'(fb_addr), exp_a[k]);
            chk("stall_data", 32'(fb_wdata), 32'h3C7);
            if (fb_ready) k++;
        end
        @(posedge clk); #1;
        io_we = 1'b0; io_addr = 2'd3; fb_ready = 1'b1;
        chk("stall_hs_count", 32'(k), 32'd16);
        @(negedge clk);
        chk("stall_end_we", 32'(fb_we), 32'd0);
        chk("stall_end_ctrl", io_rdata, IRQ_V);

        // Reset pulse in the middle of a fill
        wr(2'd0, {16'd0, 16'd0});
        wr(2'd1, {16'd4, 16'd4});
        wr(2'd3, 32'd1);
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort_we", 32'(fb_we), 32'd0);
        chk("abort_ctrl", io_rdata, 32'd0);
        @(posedge clk); #2 resetn = 1'b1;
        nwr = 0;
        repeat (10) begin
            @(negedge clk);
            if (fb_we) nwr++;
        end
        chk("abort_writes", 32'(nwr), 32'd0);
        chk("abort_idle", io_rdata, 32'd0);
        io_addr = 2'd1; #1; chk("abort_size", io_rdata, 32'd0);
        io_addr = 2'd3;

        // Single pixel completion, then acknowledge
        wr(2'd0, {16'd0, 16'd7});
        wr(2'd1, {16'd1, 16'd1});
        wr(2'd2, 32'h111);
        exp_a[0] = 7;
        check_seq("pix1", 1, 12'h111);
`ifdef FB_FILL_IRQ_EN
        chk("irq_set", 32'(irq), 32'd1);
        wr(2'd3, 32'h2);
        chk("irq_clr", 32'(irq), 32'd0);
`else
        wr(2'd3, 32'h2);
        chk("irq_absent", 32'(io_rdata[2]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_fill.md
FB_FILL -- requirements
Module: fb_fill

Interface
REQ-001 SHALL have parameter FB_W, default 320: framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 240: framebuffer height in pixels.
REQ-003 SHALL have parameter PIX_W, default 12: pixel width, 3 x VGA_BITS.
REQ-004 SHALL have parameter FB_AW, default 17: framebuffer pixel-address width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port io_we, input, 1 bit: CPU register write strobe.
REQ-008 SHALL have port io_addr, input, 2 bits: register select. 0 ORIGIN {y[31:16],x[15:0]}; 1 SIZE {h[31:16],w[15:0]}; 2 COLOR[PIX_W-1:0]; 3 CTRL.
REQ-009 SHALL have port io_wdata, input, 32 bits: register write data.
REQ-010 SHALL have port io_rdata, output, 32 bits: combinational readback of the register at io_addr; CTRL reads {29'b0, irq_pend, err, busy}.
REQ-011 SHALL have port fb_we, output, 1 bit: pixel write request.
REQ-012 SHALL have port fb_addr, output, FB_AW bits: pixel address, y*FB_W+x.
REQ-013 SHALL have port fb_wdata, output, PIX_W bits: pixel colour.
REQ-014 SHALL have port fb_ready, input, 1 bit: a write completes on a cycle where fb_we and fb_ready are both high.

Function
REQ-015 SHALL accept register writes in every state; a fill SHALL use ORIGIN/SIZE/COLOR snapshots taken at start.
REQ-016 SHALL start a fill on an io_we to CTRL with io_wdata[0]=1 while in IDLE; the same write while busy SHALL be ignored with no side effects.
REQ-017 SHALL use FSM states IDLE -> CLIP (1 cycle) -> FILL -> IDLE; busy=1 in CLIP and FILL.
REQ-018 SHALL, in CLIP, clip the rectangle to the framebuffer: x1=min(x+w,FB_W), y1=min(y+h,FB_H).
REQ-019 SHALL set err=1 and return to IDLE with no writes if x>=FB_W, y>=FB_H, w=0 or h=0.
REQ-020 SHALL assert the first fb_we on the cycle after CLIP (two cycles after the start write).
REQ-021 SHALL scan rows top to bottom and pixels left to right within a row.
REQ-022 SHALL hold fb_we, fb_addr and fb_wdata stable while fb_we=1 and fb_ready=0.
REQ-023 SHALL sustain one pixel per cycle while fb_ready=1, including across row changes (no bubble).
REQ-024 SHALL compute addresses incrementally (row base += FB_W) with no multiplier in the per-pixel path.
REQ-025 SHALL, on the handshake of the last pixel, deassert fb_we and return to IDLE on the next cycle.
REQ-026 SHALL clear err on every accepted start.
REQ-027 SHALL clear err and irq_pend on a CTRL write with io_wdata[1]=1; this SHALL win over simultaneous setting of irq_pend.

Reset
REQ-028 SHALL, on resetn low at any time including mid-fill, immediately enter IDLE and drive fb_we=0, busy=0, err=0, irq_pend=0.
REQ-029 SHALL reset fb_addr and fb_wdata to 0, and ORIGIN, SIZE and COLOR to 0.
REQ-030 SHALL NOT resume an aborted fill after reset is released.

Configuration
REQ-031 SHALL, with FB_FILL_IRQ_EN defined, add output irq (1 bit) equal to irq_pend; irq_pend is set on the cycle FILL exits or CLIP rejects.
REQ-032 SHALL, without FB_FILL_IRQ_EN, have no irq port and read irq_pend as constant 0.

Verification
REQ-033 SHALL pass: ORIGIN=(2,1), SIZE=(3,2), COLOR=0xF00, start, fb_ready=1 -> writes to addresses 322, 323, 324, 642, 643, 644 with data 0xF00 on six consecutive cycles, then busy=0.
REQ-034 SHALL pass: ORIGIN=(318,239), SIZE=(10,10) -> exactly two writes, to 76798 and 76799, with err=0.
REQ-035 SHALL pass: SIZE=(0,5) or ORIGIN x=320 -> no fb_we, err=1, busy=0 three cycles after the start write.
REQ-036 SHALL pass: fb_ready toggled pseudo-randomly during a 4x4 fill -> 16 handshakes, in order, with no outputs changing while stalled.
REQ-037 SHALL pass: resetn pulsed low mid-fill -> fb_we=0 in the same cycle, IDLE after release, and no further writes.
REQ-038 SHALL pass, with FB_FILL_IRQ_EN: a completed fill -> irq=1; CTRL write 0x2 -> irq=0 on the next cycle.
